// File: rtl/apb_arb_master.sv
// apb_arb_master: shares one APB slave port between two requesters.
// Round-robin grant in IDLE, SETUP/ACCESS sequencing with PREADY wait states,
// ACCESS-phase timeout, and a one-cycle response pulse back to the owner.
module apb_arb_master #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // Requester 0
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic                  r0_write,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rsp_valid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_err,
  // Requester 1
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic                  r1_write,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_err,
  // APB master port
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  // Counter only needs to reach TIMEOUT-1: the abort fires on the cycle it would hit TIMEOUT.
  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q;
  logic                  last_q;   // requester granted most recently (1 at reset -> r0 wins first tie)
  logic                  owner_q;  // requester owning the in-flight transfer
  logic                  grant;
  logic                  accept;
  logic                  timeout_hit;
  logic                  done;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SETUP on accept, SETUP -> ACCESS, ACCESS -> IDLE on done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs: APB phase decode and round-robin ready, ties go away from the last winner.
  always_comb begin
    grant    = (r0_valid && r1_valid) ? ~last_q : r1_valid;
    PSEL     = (state_q != StIdle);
    PENABLE  = (state_q == StAccess);
    busy     = (state_q != StIdle);
    r0_ready = (state_q == StIdle) && r0_valid && !grant;
    r1_ready = (state_q == StIdle) && r1_valid && grant;
    accept   = r0_ready || r1_ready;
  end

  // Completion/abort decode and the response payload presented to the owner.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (state_q == StAccess) && !PREADY && (cnt_q == CntLast);
    done        = (state_q == StAccess) && (PREADY || timeout_hit);
    if (timeout_hit) begin
      rsp_data = '0;
      rsp_err  = 1'b1;
    end else begin
      rsp_data = PWRITE ? '0 : PRDATA;
      rsp_err  = PSLVERR;
    end
  end

  // Wait-state counter, cleared on every accept (i.e. on entry to SETUP).
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == StAccess) && !PREADY) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Command capture; the APB payload keeps its last value while idle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
    end else if (accept) begin
      owner_q <= grant;
      last_q  <= grant;
      PADDR   <= grant ? r1_addr  : r0_addr;
      PWRITE  <= grant ? r1_write : r0_write;
      PWDATA  <= grant ? r1_wdata : r0_wdata;
    end
  end

  // Response return: rsp_valid pulses for the owner only; rdata/err hold between pulses.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r0_rsp_valid <= 1'b0;
      r0_rdata     <= '0;
      r0_err       <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r1_rdata     <= '0;
      r1_err       <= 1'b0;
    end else begin
      r0_rsp_valid <= done && !owner_q;
      r1_rsp_valid <= done && owner_q;
      if (done && !owner_q) begin
        r0_rdata <= rsp_data;
        r0_err   <= rsp_err;
      end
      if (done && owner_q) begin
        r1_rdata <= rsp_data;
        r1_err   <= rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: register-slave model, directed steps, random
// transfers checked against a transaction-level reference model.
module tb_apb_arb_master;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          r0_valid, r0_ready, r0_write, r0_rsp_valid, r0_err;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_ready, r1_write, r1_rsp_valid, r1_err;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR, busy;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_arb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_write(r0_write),
    .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_write(r1_write),
    .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- 8 x 32 register slave with programmable waits ----------------
  logic [31:0] slv_mem [8] = '{default: '0};
  int          wait_n = 0;
  bit          stuck  = 1'b0;
  bit          serr_n = 1'b0;
  int          acc_cnt;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) acc_cnt <= 0;
    else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) slv_mem[PADDR[4:2]] <= PWDATA;
  end

  assign PREADY  = PSEL && PENABLE && !stuck && (acc_cnt >= wait_n);
  assign PSLVERR = PREADY && serr_n;
  assign PRDATA  = slv_mem[PADDR[4:2]];

  // ---------------- reference model state ----------------
  logic [31:0] mem_m [8] = '{default: '0};
  logic [31:0] rdata_m [2];
  logic        err_m [2];
  bit          last_m;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int r);
    return (r != 0) ? r1_ready : r0_ready;
  endfunction
  function automatic logic rv(input int r);
    return (r != 0) ? r1_rsp_valid : r0_rsp_valid;
  endfunction
  function automatic logic [DW-1:0] rd(input int r);
    return (r != 0) ? r1_rdata : r0_rdata;
  endfunction
  function automatic logic er(input int r);
    return (r != 0) ? r1_err : r0_err;
  endfunction

  task automatic drive(input int r, input logic v, input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] d);
    if (r == 0) begin
      r0_valid = v; r0_addr = a; r0_write = w; r0_wdata = d;
    end else begin
      r1_valid = v; r1_addr = a; r1_write = w; r1_wdata = d;
    end
  endtask

  // One transfer from an idle master; optionally the other requester pesters while busy.
  task automatic xfer(input int req, input logic [AW-1:0] addr, input bit wr,
                      input logic [DW-1:0] wd, input int waits, input bit se, input bit stk,
                      input bit pester, input string tag);
    int          lat;
    int          oth;
    logic [31:0] exp_d;
    logic        exp_e;
    oth = 1 - req;
    @(posedge PCLK); #1;
    wait_n = waits; serr_n = se; stuck = stk;
    lat = 3 + (stk ? int'(TO) - 1 : waits);
    if (stk) begin
      exp_d = '0; exp_e = 1'b1;
    end else begin
      exp_d = wr ? 32'h0 : mem_m[addr[4:2]];
      exp_e = se;
      if (wr && !se) mem_m[addr[4:2]] = wd;
    end
    drive(req, 1'b1, addr, wr, wd);
    @(negedge PCLK);
    chk({tag, "/ready"}, rdy(req), 1);
    chk({tag, "/other_ready"}, rdy(oth), 0);
    last_m = req[0];
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(posedge PCLK); #1;
      if (cyc == 1) begin
        drive(req, 1'b0, AW'($urandom), 1'($urandom), $urandom);
        if (pester) drive(oth, 1'b1, AW'($urandom), 1'($urandom), $urandom);
      end
      if (cyc == lat) drive(oth, 1'b0, AW'($urandom), 1'($urandom), $urandom);
      @(negedge PCLK);
      if (cyc < lat) begin
        chk({tag, "/psel"}, PSEL, 1);
        chk({tag, "/penable"}, PENABLE, (cyc >= 2));
        chk({tag, "/busy"}, busy, 1);
        chk({tag, "/paddr"}, PADDR, addr);
        chk({tag, "/pwrite"}, PWRITE, wr);
        chk({tag, "/pwdata"}, PWDATA, wd);
        chk({tag, "/rsp_early"}, rv(req), 0);
        chk({tag, "/oth_rsp"}, rv(oth), 0);
        chk({tag, "/oth_ready_busy"}, rdy(oth), 0);
      end else begin
        chk({tag, "/rsp_valid"}, rv(req), 1);
        chk({tag, "/oth_rsp_end"}, rv(oth), 0);
        chk({tag, "/rdata"}, rd(req), exp_d);
        chk({tag, "/err"}, er(req), exp_e);
        chk({tag, "/psel_end"}, PSEL, 0);
        chk({tag, "/busy_end"}, busy, 0);
        chk({tag, "/oth_rdata_hold"}, rd(oth), rdata_m[oth]);
        chk({tag, "/oth_err_hold"}, er(oth), err_m[oth]);
      end
    end
    rdata_m[req] = exp_d;
    err_m[req]   = exp_e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] c_addr [2][4];
    logic          c_wr   [2][4];
    logic [DW-1:0] c_wd   [2][4];
    int            idx [2];
    int            next_free, due, due_req, last_acc;
    logic [31:0]   due_d;
    logic          due_e;
    int            order [$];
    bit            idle_m, g, acc0, acc1, fin;
    int            rq, wt;
    logic [AW-1:0] ra;
    logic [DW-1:0] rwd;
    bit            rwr, rse, rstk, rpest;

    // ---- reset values ----
    PRESETn = 1'b0;
    drive(0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);
    rdata_m[0] = '0; rdata_m[1] = '0; err_m[0] = 1'b0; err_m[1] = 1'b0; last_m = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst/psel", PSEL, 0);
    chk("rst/penable", PENABLE, 0);
    chk("rst/busy", busy, 0);
    chk("rst/pwrite", PWRITE, 0);
    chk("rst/paddr", PADDR, 0);
    chk("rst/pwdata", PWDATA, 0);
    chk("rst/r0_rsp", r0_rsp_valid, 0);
    chk("rst/r1_rsp", r1_rsp_valid, 0);
    chk("rst/r0_rdata", r0_rdata, 0);
    chk("rst/r1_err", r1_err, 0);
    #2 PRESETn = 1'b1;

    // ---- contention: both requesters continuously valid, 4 commands each ----
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        c_addr[r][k] = AW'($urandom);
        c_wr[r][k]   = 1'($urandom);
        c_wd[r][k]   = $urandom;
      end
      idx[r] = 0;
    end
    wait_n = 0; serr_n = 1'b0; stuck = 1'b0;
    next_free = 0; due = -1; due_req = 0; due_d = '0; due_e = 1'b0; last_acc = -1;
    fin = 1'b0;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(posedge PCLK); #1;
      for (int r = 0; r < 2; r++) begin
        if (idx[r] < 4) drive(r, 1'b1, c_addr[r][idx[r]], c_wr[r][idx[r]], c_wd[r][idx[r]]);
        else drive(r, 1'b0, '0, 1'b0, '0);
      end
      @(negedge PCLK);
      idle_m = (c >= next_free);
      g      = (r0_valid && r1_valid) ? !last_m : r1_valid;
      acc0   = idle_m && r0_valid && !g;
      acc1   = idle_m && r1_valid && g;
      chk("cont/r0_ready", r0_ready, acc0);
      chk("cont/r1_ready", r1_ready, acc1);
      chk("cont/r0_rsp", r0_rsp_valid, (c == due) && (due_req == 0));
      chk("cont/r1_rsp", r1_rsp_valid, (c == due) && (due_req == 1));
      if (c == due) begin
        chk("cont/rdata", rd(due_req), due_d);
        chk("cont/err", er(due_req), due_e);
        rdata_m[due_req] = due_d;
        err_m[due_req]   = due_e;
      end
      if (acc0 || acc1) begin
        rq      = acc1 ? 1 : 0;
        due_req = rq;
        due_d   = c_wr[rq][idx[rq]] ? 32'h0 : mem_m[c_addr[rq][idx[rq]][4:2]];
        due_e   = 1'b0;
        if (c_wr[rq][idx[rq]]) mem_m[c_addr[rq][idx[rq]][4:2]] = c_wd[rq][idx[rq]];
        due       = c + 3;
        next_free = c + 3;
        last_m    = g;
        if (last_acc >= 0) chk("cont/accept_gap", c - last_acc, 3);
        last_acc = c;
        idx[rq]++;
        order.push_back(rq);
      end
      fin = (idx[0] == 4) && (idx[1] == 4) && (c >= due);
    end
    chk("cont/finished", fin, 1);
    chk("cont/grant_count", order.size(), 8);
    foreach (order[i]) chk("cont/grant_order", order[i], i % 2);
    drive(0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);

    // ---- directed: zero-wait write, read-back, wait states, timeout ----
    xfer(0, 8'h08, 1'b1, 32'hA5A5_0001, 0, 1'b0, 1'b0, 1'b0, "wr0");
    chk("wr0/slave_reg2", slv_mem[2], 32'hA5A5_0001);
    xfer(1, 8'h08, 1'b0, $urandom, 0, 1'b0, 1'b0, 1'b1, "rd1");
    chk("rd1/value", r1_rdata, 32'hA5A5_0001);
    xfer(0, 8'h10, 1'b1, 32'h0BAD_F00D, 3, 1'b1, 1'b0, 1'b1, "wait_err");
    chk("wait_err/no_write", slv_mem[4], mem_m[4]);
    xfer(1, 8'h14, 1'b0, $urandom, 0, 1'b0, 1'b1, 1'b0, "timeout");
    xfer(1, 8'h08, 1'b0, $urandom, 3, 1'b0, 1'b0, 1'b0, "post_timeout");

    // ---- random transfers ----
    for (int n = 0; n < 24; n++) begin
      rq    = int'($urandom_range(0, 1));
      ra    = AW'($urandom);
      rwr   = 1'($urandom);
      rwd   = $urandom;
      wt    = int'($urandom_range(0, 3));
      rse   = ($urandom_range(0, 5) == 0);
      rstk  = ($urandom_range(0, 7) == 0);
      rpest = 1'($urandom);
      xfer(rq, ra, rwr, rwd, wt, rse, rstk, rpest, "rand");
    end

    // ---- asynchronous reset during ACCESS ----
    @(posedge PCLK); #1;
    stuck = 1'b1; wait_n = 0; serr_n = 1'b0;
    drive(0, 1'b1, 8'h04, 1'b1, 32'h1234_5678);
    @(negedge PCLK);
    chk("arst/accept", r0_ready, 1);
    @(posedge PCLK); #1;
    drive(0, 1'b0, '0, 1'b0, '0);
    @(posedge PCLK);
    @(negedge PCLK);
    chk("arst/in_access", PENABLE, 1);
    #1 PRESETn = 1'b0;
    #1;
    chk("arst/psel", PSEL, 0);
    chk("arst/penable", PENABLE, 0);
    chk("arst/busy", busy, 0);
    chk("arst/rsp", r0_rsp_valid, 0);
    chk("arst/rdata", r0_rdata, 0);
    rdata_m[0] = '0; rdata_m[1] = '0; err_m[0] = 1'b0; err_m[1] = 1'b0; last_m = 1'b1;
    @(posedge PCLK); #1;
    chk("arst/no_rsp", r0_rsp_valid, 0);
    stuck = 1'b0;
    drive(0, 1'b1, 8'h08, 1'b0, $urandom);
    drive(1, 1'b1, 8'h0C, 1'b1, $urandom);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("arst/tie_r0", r0_ready, 1);
    chk("arst/tie_r1", r1_ready, 0);
    @(posedge PCLK); #1;
    drive(0, 1'b0, '0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, '0);
    @(posedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
    chk("arst/post_rsp", r0_rsp_valid, 1);
    chk("arst/post_r1", r1_rsp_valid, 0);
    chk("arst/post_rdata", r0_rdata, mem_m[2]);
    chk("arst/post_err", r0_err, 0);
    chk("arst/aborted_no_write", slv_mem[1], mem_m[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
